ieu_rs: RTL and testbench
=========================

Name: ieu_rs

Overview:
Integer reservation station feeding the IEU decode stage. Accepts renamed instructions from dispatch and holds them until both source operands are available. Snoops the CDB for operand wakeup. Issues the oldest ready instruction per cycle as opcode, iaddr, insn, src_a, src_b, tag and valid to the IEU, with back-pressure support.

Parameters:
RS_DEPTH, 8, number of entries; power of two, ≥2; age counter width = $clog2(RS_DEPTH)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
i_flush  in  1  synchronous pipeline flush (mispredict)
i_cdb_en  in  1  CDB broadcast valid
i_cdb_tag  in  TAG_WIDTH  CDB producer tag
i_cdb_data  in  DATA_WIDTH  CDB result
i_dsp_en  in  1  dispatch valid
i_dsp_opcode  in  procyon_opcode_t  opcode
i_dsp_iaddr  in  ADDR_WIDTH  instruction address
i_dsp_insn  in  DATA_WIDTH  raw instruction
i_dsp_src_a_rdy / i_dsp_src_b_rdy  in  1 each  operand already available
i_dsp_src_a_tag / i_dsp_src_b_tag  in  TAG_WIDTH each  producer tag if not ready
i_dsp_src_a_data / i_dsp_src_b_data  in  DATA_WIDTH each  operand value if ready
i_dsp_dst_tag  in  TAG_WIDTH  destination tag
o_rs_stall  out  1  all entries valid; dispatch must hold
i_stall  in  1  IEU cannot accept an issue this cycle
o_opcode, o_iaddr, o_insn, o_src_a, o_src_b, o_tag  out  type/width of matching dispatch field  issued instruction
o_valid  out  1  issued instruction valid

Behaviour:
- Reset (async, n_rst=0): all entry valid bits 0, all ages 0, o_valid=0, all other outputs 0.
- Entry state: valid, age, opcode, iaddr, insn, dst_tag, and per operand {rdy, tag, data}.
- Allocation: on i_dsp_en && !o_rs_stall, write the lowest-index free entry at the clock edge. The new entry's age is 0. Every other valid entry's age increments by 1. The age cannot overflow because at most RS_DEPTH-1 older entries exist.
- o_rs_stall = all entries valid. It is combinational from current state. A slot freed by an issue in the same cycle is not visible until the next cycle.
- i_dsp_en while o_rs_stall=1 is a protocol violation. The design ignores it, and an assertion flags it.
- CDB wakeup: for each valid entry, each operand with rdy=0 and tag==i_cdb_tag while i_cdb_en=1 latches data and sets rdy=1 at the edge.
- Dispatch bypass: if a dispatched operand has rdy=0 and its tag matches the same-cycle CDB broadcast, the entry allocates with rdy=1 and the CDB data.
- Selection: among valid entries with both operands ready, pick the largest age. Ties are impossible. Selection uses registered entry state only, so a CDB wakeup in cycle N makes the entry eligible in cycle N+1.
- Issue register: advances when (!i_stall || !o_valid).
  - On advance with a selected entry: load the entry's fields into the outputs, set o_valid=1, free the entry.
  - On advance with nothing selected: o_valid=0.
  - When not advancing: outputs hold and no entry is freed.
- Latency: an instruction dispatched ready in cycle N, into an otherwise empty RS, has o_valid=1 at cycle N+2.
- Simultaneous dispatch and issue: both take effect. The age increment applies to surviving entries only. Entries older than the issued one are not decremented; relative order is preserved.
- Flush: i_flush=1 clears all entry valid bits and o_valid at the edge. It has priority over dispatch, wakeup and issue. A dispatch in the flush cycle is dropped.
- A CDB broadcast matching no entry has no effect. One broadcast may wake multiple entries and both operands of one entry.

Decomposition:
- procyon_types package gains procyon_rs_entry_t (struct of the entry fields above). It reuses the existing procyon_opcode_t, procyon_addr_t, procyon_data_t and procyon_tag_t.
- Widths come from common.svh (DATA_WIDTH, ADDR_WIDTH, TAG_WIDTH).
- One sub-module, ieu_rs_select: combinational oldest-ready picker. It takes the ready vector and ages and returns a one-hot grant plus a found flag.

Test Plan:
1. Reset, then dispatch ADDI (both operands rdy, src_a=5, dst_tag=3) at cycle 1, i_stall=0 → o_valid=1 at cycle 3 with o_src_a=5, o_tag=3; o_valid=0 at cycle 4.
2. Dispatch op with src_a rdy=0, tag=7. CDB tag=7 data=0x1234 at cycle 4 → o_valid=1 at cycle 6 with o_src_a=0x1234. Repeat with the CDB broadcast in the dispatch cycle (bypass) → same data, issued two cycles after dispatch.
3. Dispatch tags 1,2,3 all waiting on CDB tag 9; broadcast tag 9 once → issues occur in order 1,2,3 on consecutive cycles.
4. Fill all 8 entries with non-ready ops → o_rs_stall=1. Wake one entry → o_rs_stall drops one cycle after its issue. A dispatch attempted while stalled does not create an entry.
5. Hold i_stall=1 with o_valid=1 for 3 cycles → outputs stable and RS occupancy unchanged. Release → next oldest issues.
6. Four entries valid and o_valid=1, assert i_flush → next cycle o_valid=0 and o_rs_stall=0, with no further issues without new dispatch. Repeat with n_rst asserted mid-operation → immediate clear.

Source files
------------

// File: rtl/ieu_rs_pkg.sv
// Shared widths and types for the integer reservation station.
package ieu_rs_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned TAG_WIDTH  = 6;

    typedef logic [DATA_WIDTH-1:0] procyon_data_t;
    typedef logic [ADDR_WIDTH-1:0] procyon_addr_t;
    typedef logic [TAG_WIDTH-1:0]  procyon_tag_t;

    typedef enum logic [3:0] {
        OPCODE_ADD  = 4'd0,
        OPCODE_SUB  = 4'd1,
        OPCODE_ADDI = 4'd2,
        OPCODE_AND  = 4'd3,
        OPCODE_OR   = 4'd4,
        OPCODE_XOR  = 4'd5,
        OPCODE_SLL  = 4'd6,
        OPCODE_SRL  = 4'd7,
        OPCODE_SRA  = 4'd8,
        OPCODE_SLT  = 4'd9,
        OPCODE_SLTU = 4'd10,
        OPCODE_LUI  = 4'd11,
        OPCODE_BEQ  = 4'd12,
        OPCODE_BNE  = 4'd13,
        OPCODE_JAL  = 4'd14,
        OPCODE_JALR = 4'd15
    } procyon_opcode_t;

    typedef struct packed {
        logic          rdy;
        procyon_tag_t  tag;
        procyon_data_t data;
    } procyon_rs_src_t;

    // Payload of one RS entry; valid and age live beside it since age width depends on depth.
    typedef struct packed {
        procyon_opcode_t opcode;
        procyon_addr_t   iaddr;
        procyon_data_t   insn;
        procyon_tag_t    dst_tag;
        procyon_rs_src_t src_a;
        procyon_rs_src_t src_b;
    } procyon_rs_entry_t;

    // Capture a CDB result into a waiting operand.
    function automatic procyon_rs_src_t rs_src_wakeup(
        input procyon_rs_src_t src,
        input logic            cdb_en,
        input procyon_tag_t    cdb_tag,
        input procyon_data_t   cdb_data
    );
        procyon_rs_src_t r;
        r = src;
        if (!src.rdy && cdb_en && (src.tag == cdb_tag)) begin
            r.rdy  = 1'b1;
            r.data = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/ieu_rs_select.sv
// Oldest-ready picker: one-hot grant for the ready entry with the largest age.
module ieu_rs_select #(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned AGE_W    = $clog2(RS_DEPTH)
) (
    input  logic [RS_DEPTH-1:0]            ready,
    input  logic [RS_DEPTH-1:0][AGE_W-1:0] age,
    output logic [RS_DEPTH-1:0]            grant_c,
    output logic                           found_c
);

    logic [AGE_W-1:0] best_age;
    logic [AGE_W-1:0] best_idx;

    // Strict compare keeps the lowest index if ages ever saturate to a tie.
    always_comb begin
        found_c  = 1'b0;
        best_age = '0;
        best_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ready[i] && (!found_c || (age[i] > best_age))) begin
                found_c  = 1'b1;
                best_age = age[i];
                best_idx = AGE_W'(i);
            end
        end
        grant_c = found_c ? (RS_DEPTH'(1) << best_idx) : '0;
    end

endmodule

// File: rtl/ieu_rs.sv
// Integer reservation station: holds renamed ops until operands arrive, issues oldest ready.
module ieu_rs
    import ieu_rs_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            i_flush,
    input  logic            i_cdb_en,
    input  procyon_tag_t    i_cdb_tag,
    input  procyon_data_t   i_cdb_data,
    input  logic            i_dsp_en,
    input  procyon_opcode_t i_dsp_opcode,
    input  procyon_addr_t   i_dsp_iaddr,
    input  procyon_data_t   i_dsp_insn,
    input  logic            i_dsp_src_a_rdy,
    input  logic            i_dsp_src_b_rdy,
    input  procyon_tag_t    i_dsp_src_a_tag,
    input  procyon_tag_t    i_dsp_src_b_tag,
    input  procyon_data_t   i_dsp_src_a_data,
    input  procyon_data_t   i_dsp_src_b_data,
    input  procyon_tag_t    i_dsp_dst_tag,
    output logic            o_rs_stall,
    input  logic            i_stall,
    output procyon_opcode_t o_opcode,
    output procyon_addr_t   o_iaddr,
    output procyon_data_t   o_insn,
    output procyon_data_t   o_src_a,
    output procyon_data_t   o_src_b,
    output procyon_tag_t    o_tag,
    output logic            o_valid
);

    localparam int unsigned      AGE_W   = $clog2(RS_DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [RS_DEPTH-1:0]            valid_q;
    logic [RS_DEPTH-1:0][AGE_W-1:0] age_q;
    procyon_rs_entry_t              entry_q [RS_DEPTH];

    logic [RS_DEPTH-1:0] ready;
    logic [RS_DEPTH-1:0] grant;
    logic                found;
    logic                advance;
    logic                alloc;
    logic                free_seen;
    logic [RS_DEPTH-1:0] alloc_mask;
    logic [RS_DEPTH-1:0] free_mask;
    procyon_rs_entry_t   new_entry;
    procyon_rs_entry_t   issue_entry;

    assign o_rs_stall = &valid_q;
    assign advance    = !i_stall || !o_valid;
    assign alloc      = i_dsp_en && !o_rs_stall && !i_flush;
    assign free_mask  = (advance && found) ? grant : '0;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready[i] = valid_q[i] && entry_q[i].src_a.rdy && entry_q[i].src_b.rdy;
        end
    end

    ieu_rs_select #(
        .RS_DEPTH (RS_DEPTH),
        .AGE_W    (AGE_W)
    ) u_select (
        .ready   (ready),
        .age     (age_q),
        .grant_c (grant),
        .found_c (found)
    );

    // Lowest-index free slot, judged on registered valid bits only.
    always_comb begin
        alloc_mask = '0;
        free_seen  = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!valid_q[i] && !free_seen) begin
                alloc_mask[i] = alloc;
                free_seen     = 1'b1;
            end
        end
    end

    // Incoming entry, with same-cycle CDB bypass on waiting operands.
    always_comb begin
        new_entry.opcode  = i_dsp_opcode;
        new_entry.iaddr   = i_dsp_iaddr;
        new_entry.insn    = i_dsp_insn;
        new_entry.dst_tag = i_dsp_dst_tag;
        new_entry.src_a   = rs_src_wakeup('{rdy: i_dsp_src_a_rdy, tag: i_dsp_src_a_tag,
                                            data: i_dsp_src_a_data},
                                          i_cdb_en, i_cdb_tag, i_cdb_data);
        new_entry.src_b   = rs_src_wakeup('{rdy: i_dsp_src_b_rdy, tag: i_dsp_src_b_tag,
                                            data: i_dsp_src_b_data},
                                          i_cdb_en, i_cdb_tag, i_cdb_data);
    end

    always_comb begin
        issue_entry = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                issue_entry = entry_q[i];
            end
        end
    end

    // Entry storage: allocate, free on issue, age surviving entries, CDB wakeup.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
            age_q   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (i_flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (alloc_mask[i]) begin
                    valid_q[i] <= 1'b1;
                    age_q[i]   <= '0;
                    entry_q[i] <= new_entry;
                end else begin
                    if (free_mask[i]) begin
                        valid_q[i] <= 1'b0;
                    end else if (alloc && valid_q[i] && (age_q[i] != AGE_MAX)) begin
                        age_q[i] <= age_q[i] + 1'b1;
                    end
                    entry_q[i].src_a <= rs_src_wakeup(entry_q[i].src_a, i_cdb_en,
                                                      i_cdb_tag, i_cdb_data);
                    entry_q[i].src_b <= rs_src_wakeup(entry_q[i].src_b, i_cdb_en,
                                                      i_cdb_tag, i_cdb_data);
                end
            end
        end
    end

    // Issue register toward the IEU; holds while the IEU stalls a valid op.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_valid  <= 1'b0;
            o_opcode <= OPCODE_ADD;
            o_iaddr  <= '0;
            o_insn   <= '0;
            o_src_a  <= '0;
            o_src_b  <= '0;
            o_tag    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (advance) begin
            o_valid <= found;
            if (found) begin
                o_opcode <= issue_entry.opcode;
                o_iaddr  <= issue_entry.iaddr;
                o_insn   <= issue_entry.insn;
                o_src_a  <= issue_entry.src_a.data;
                o_src_b  <= issue_entry.src_b.data;
                o_tag    <= issue_entry.dst_tag;
            end
        end
    end

    // Dispatching into a full station is a protocol violation; the request is dropped.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            assert (!(i_dsp_en && o_rs_stall))
            else $warning("ieu_rs: dispatch while o_rs_stall is high, request dropped");
        end
    end

endmodule

// File: tb/tb_ieu_rs.sv
// Directed bench for ieu_rs: vector table plus multi-cycle corner sequences.
module tb_ieu_rs;
    import ieu_rs_pkg::*;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            i_flush;
    logic            i_cdb_en;
    procyon_tag_t    i_cdb_tag;
    procyon_data_t   i_cdb_data;
    logic            i_dsp_en;
    procyon_opcode_t i_dsp_opcode;
    procyon_addr_t   i_dsp_iaddr;
    procyon_data_t   i_dsp_insn;
    logic            i_dsp_src_a_rdy;
    logic            i_dsp_src_b_rdy;
    procyon_tag_t    i_dsp_src_a_tag;
    procyon_tag_t    i_dsp_src_b_tag;
    procyon_data_t   i_dsp_src_a_data;
    procyon_data_t   i_dsp_src_b_data;
    procyon_tag_t    i_dsp_dst_tag;
    logic            o_rs_stall;
    logic            i_stall;
    procyon_opcode_t o_opcode;
    procyon_addr_t   o_iaddr;
    procyon_data_t   o_insn;
    procyon_data_t   o_src_a;
    procyon_data_t   o_src_b;
    procyon_tag_t    o_tag;
    logic            o_valid;

    always #5 clk = ~clk;

    ieu_rs #(.RS_DEPTH(8)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_flush          (i_flush),
        .i_cdb_en         (i_cdb_en),
        .i_cdb_tag        (i_cdb_tag),
        .i_cdb_data       (i_cdb_data),
        .i_dsp_en         (i_dsp_en),
        .i_dsp_opcode     (i_dsp_opcode),
        .i_dsp_iaddr      (i_dsp_iaddr),
        .i_dsp_insn       (i_dsp_insn),
        .i_dsp_src_a_rdy  (i_dsp_src_a_rdy),
        .i_dsp_src_b_rdy  (i_dsp_src_b_rdy),
        .i_dsp_src_a_tag  (i_dsp_src_a_tag),
        .i_dsp_src_b_tag  (i_dsp_src_b_tag),
        .i_dsp_src_a_data (i_dsp_src_a_data),
        .i_dsp_src_b_data (i_dsp_src_b_data),
        .i_dsp_dst_tag    (i_dsp_dst_tag),
        .o_rs_stall       (o_rs_stall),
        .i_stall          (i_stall),
        .o_opcode         (o_opcode),
        .o_iaddr          (o_iaddr),
        .o_insn           (o_insn),
        .o_src_a          (o_src_a),
        .o_src_b          (o_src_b),
        .o_tag            (o_tag),
        .o_valid          (o_valid)
    );

    typedef struct {
        logic          dsp_en;
        procyon_tag_t  dst;
        logic          a_rdy;
        procyon_tag_t  a_tag;
        procyon_data_t a_data;
        logic          cdb_en;
        procyon_tag_t  cdb_tag;
        procyon_data_t cdb_data;
        logic          exp_valid;
        procyon_data_t exp_src_a;
        procyon_tag_t  exp_tag;
    } vec_t;

    localparam int unsigned NVEC = 13;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_err = 0;
    procyon_tag_t got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic dsp_en, input procyon_tag_t dst, input logic a_rdy,
                                input procyon_tag_t a_tag, input procyon_data_t a_data,
                                input logic cdb_en, input procyon_tag_t cdb_tag,
                                input procyon_data_t cdb_data, input logic exp_valid,
                                input procyon_data_t exp_src_a, input procyon_tag_t exp_tag);
        vec_t v;
        v.dsp_en = dsp_en;   v.dst = dst;         v.a_rdy = a_rdy;
        v.a_tag = a_tag;     v.a_data = a_data;   v.cdb_en = cdb_en;
        v.cdb_tag = cdb_tag; v.cdb_data = cdb_data;
        v.exp_valid = exp_valid; v.exp_src_a = exp_src_a; v.exp_tag = exp_tag;
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // iaddr, insn and src_b are derived from dst so every issued field is checkable.
    task automatic drive_dsp(input logic en, input procyon_tag_t dst,
                             input logic a_rdy, input procyon_tag_t a_tag, input procyon_data_t a_data,
                             input logic b_rdy, input procyon_tag_t b_tag);
        i_dsp_en         = en;
        i_dsp_opcode     = OPCODE_ADDI;
        i_dsp_dst_tag    = dst;
        i_dsp_iaddr      = 32'h1000 + 32'(dst);
        i_dsp_insn       = 32'h0000_0013 | (32'(dst) << 7);
        i_dsp_src_a_rdy  = a_rdy;
        i_dsp_src_a_tag  = a_tag;
        i_dsp_src_a_data = a_data;
        i_dsp_src_b_rdy  = b_rdy;
        i_dsp_src_b_tag  = b_tag;
        i_dsp_src_b_data = 32'(dst) * 2;
    endtask

    task automatic drive_cdb(input logic en, input procyon_tag_t tag, input procyon_data_t data);
        i_cdb_en   = en;
        i_cdb_tag  = tag;
        i_cdb_data = data;
    endtask

    task automatic idle();
        i_dsp_en = 1'b0;
        drive_cdb(1'b0, 6'd0, 32'h0);
    endtask

    task automatic check_issue(input string name, input procyon_tag_t tag, input procyon_data_t src_a);
        check({name, "_valid"}, 32'(o_valid), 32'd1);
        check({name, "_tag"}, 32'(o_tag), 32'(tag));
        check({name, "_src_a"}, o_src_a, src_a);
        check({name, "_opcode"}, 32'(o_opcode), 32'(OPCODE_ADDI));
        check({name, "_iaddr"}, o_iaddr, 32'h1000 + 32'(tag));
        check({name, "_insn"}, o_insn, 32'h0000_0013 | (32'(tag) << 7));
    endtask

    initial begin
        n_rst   = 1'b0;
        i_flush = 1'b0;
        i_stall = 1'b0;
        idle();
        drive_dsp(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);

        // Vector table: outputs checked at each negedge, then that cycle's inputs are driven.
        vecs[0]  = mk(1'b1, 6'd3, 1'b1, 6'd0, 32'h5,    1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);
        vecs[1]  = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);
        vecs[2]  = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b1, 32'h5,    6'd3);
        vecs[3]  = mk(1'b1, 6'd4, 1'b0, 6'd7, 32'hdead, 1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);
        vecs[4]  = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);
        vecs[5]  = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b1, 6'd7,  32'h1234, 1'b0, 32'h0,    6'd0);
        vecs[6]  = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);
        vecs[7]  = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b1, 32'h1234, 6'd4);
        vecs[8]  = mk(1'b1, 6'd5, 1'b0, 6'd7, 32'hdead, 1'b1, 6'd7,  32'h1234, 1'b0, 32'h0,    6'd0);
        vecs[9]  = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);
        vecs[10] = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b1, 6'd12, 32'h7777, 1'b1, 32'h1234, 6'd5);
        vecs[11] = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);
        vecs[12] = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'h0,    1'b0, 6'd0,  32'h0,    1'b0, 32'h0,    6'd0);

        repeat (2) step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_stall", 32'(o_rs_stall), 32'd0);
        n_rst = 1'b1;
        step();
        check("post_rst_tag", 32'(o_tag), 32'd0);
        check("post_rst_src_a", o_src_a, 32'h0);
        check("post_rst_opcode", 32'(o_opcode), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_stall", i), 32'(o_rs_stall), 32'd0);
            if (vecs[i].exp_valid) begin
                check_issue($sformatf("v%0d", i), vecs[i].exp_tag, vecs[i].exp_src_a);
                check($sformatf("v%0d_src_b", i), o_src_b, 32'(vecs[i].exp_tag) * 2);
            end
            drive_dsp(vecs[i].dsp_en, vecs[i].dst, vecs[i].a_rdy, vecs[i].a_tag, vecs[i].a_data,
                      1'b1, 6'd0);
            drive_cdb(vecs[i].cdb_en, vecs[i].cdb_tag, vecs[i].cdb_data);
            step();
        end
        idle();

        // One broadcast wakes three entries (and both operands of dst 2); age order kept.
        drive_dsp(1'b1, 6'd1, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0);  step();
        drive_dsp(1'b1, 6'd2, 1'b0, 6'd9, 32'h0, 1'b0, 6'd9);  step();
        drive_dsp(1'b1, 6'd3, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0);  step();
        idle();
        check("wake_early_valid", 32'(o_valid), 32'd0);
        drive_cdb(1'b1, 6'd9, 32'h99);                          step();
        idle();                                                 step();
        check_issue("wake1", 6'd1, 32'h99);                     step();
        check_issue("wake2", 6'd2, 32'h99);
        check("wake2_src_b", o_src_b, 32'h99);                  step();
        check_issue("wake3", 6'd3, 32'h99);                     step();
        check("wake_done_valid", 32'(o_valid), 32'd0);

        // Fill all entries with waiting ops, then probe the full-station behaviour.
        for (int k = 0; k < 7; k++) begin
            drive_dsp(1'b1, 6'(10 + k), 1'b0, 6'(20 + k), 32'h0, 1'b1, 6'd0);
            step();
        end
        check("seven_stall", 32'(o_rs_stall), 32'd0);
        drive_dsp(1'b1, 6'd17, 1'b0, 6'd27, 32'h0, 1'b1, 6'd0); step();
        check("full_stall", 32'(o_rs_stall), 32'd1);
        drive_dsp(1'b1, 6'd50, 1'b1, 6'd0, 32'h50, 1'b1, 6'd0); step();
        idle();
        check("full_drop_stall", 32'(o_rs_stall), 32'd1);
        check("full_drop_valid", 32'(o_valid), 32'd0);
        drive_cdb(1'b1, 6'd20, 32'ha0);                         step();
        idle();
        check("full_woken_stall", 32'(o_rs_stall), 32'd1);
        check("full_woken_valid", 32'(o_valid), 32'd0);         step();
        check_issue("full_issue", 6'd10, 32'ha0);
        check("full_freed_stall", 32'(o_rs_stall), 32'd0);
        for (int k = 1; k < 8; k++) begin
            drive_cdb(1'b1, 6'(20 + k), 32'(k));
            step();
            if (o_valid) got.push_back(o_tag);
        end
        idle();
        for (int c = 0; c < 6; c++) begin
            step();
            if (o_valid) got.push_back(o_tag);
        end
        check("drain_count", 32'(got.size()), 32'd7);
        for (int j = 0; j < got.size(); j++) begin
            check($sformatf("drain%0d_tag", j), 32'(got[j]), 32'(11 + j));
        end

        // IEU back-pressure holds the issued op and the remaining entries.
        drive_dsp(1'b1, 6'd30, 1'b1, 6'd0, 32'h30, 1'b1, 6'd0); step();
        drive_dsp(1'b1, 6'd31, 1'b1, 6'd0, 32'h31, 1'b1, 6'd0); step();
        check_issue("stall_first", 6'd30, 32'h30);
        i_stall = 1'b1;
        drive_dsp(1'b1, 6'd32, 1'b1, 6'd0, 32'h32, 1'b1, 6'd0); step();
        idle();
        for (int c = 0; c < 3; c++) begin
            check_issue($sformatf("stall_hold%0d", c), 6'd30, 32'h30);
            if (c < 2) step();
        end
        i_stall = 1'b0;                                         step();
        check_issue("stall_rel1", 6'd31, 32'h31);               step();
        check_issue("stall_rel2", 6'd32, 32'h32);               step();
        check("stall_empty_valid", 32'(o_valid), 32'd0);

        // Flush with four valid entries and a held issue; flush beats dispatch and wakeup.
        drive_dsp(1'b1, 6'd40, 1'b1, 6'd0, 32'h40, 1'b1, 6'd0); step();
        drive_dsp(1'b1, 6'd41, 1'b0, 6'd60, 32'h0, 1'b1, 6'd0); step();
        i_stall = 1'b1;
        drive_dsp(1'b1, 6'd42, 1'b0, 6'd61, 32'h0, 1'b1, 6'd0); step();
        drive_dsp(1'b1, 6'd43, 1'b0, 6'd62, 32'h0, 1'b1, 6'd0); step();
        drive_dsp(1'b1, 6'd44, 1'b0, 6'd63, 32'h0, 1'b1, 6'd0); step();
        check_issue("pre_flush", 6'd40, 32'h40);
        i_flush = 1'b1;
        drive_dsp(1'b1, 6'd45, 1'b1, 6'd0, 32'h45, 1'b1, 6'd0);
        drive_cdb(1'b1, 6'd60, 32'h60);                         step();
        i_flush = 1'b0;
        i_stall = 1'b0;
        idle();
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_stall", 32'(o_rs_stall), 32'd0);
        begin
            int issues = 0;
            for (int c = 0; c < 8; c++) begin
                if (c < 4) drive_cdb(1'b1, 6'(60 + c), 32'(c));
                else       idle();
                step();
                if (o_valid) issues++;
            end
            check("flush_no_issue", 32'(issues), 32'd0);
        end

        // Asynchronous reset mid-operation clears outputs immediately.
        drive_dsp(1'b1, 6'd46, 1'b1, 6'd0, 32'h46, 1'b1, 6'd0); step();
        drive_dsp(1'b1, 6'd47, 1'b0, 6'd33, 32'h0, 1'b1, 6'd0); step();
        idle();
        check_issue("pre_rst", 6'd46, 32'h46);
        #2 n_rst = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_tag", 32'(o_tag), 32'd0);
        check("arst_src_a", o_src_a, 32'h0);
        check("arst_stall", 32'(o_rs_stall), 32'd0);
        step();
        n_rst = 1'b1;
        begin
            int issues = 0;
            for (int c = 0; c < 5; c++) begin
                if (c == 0) drive_cdb(1'b1, 6'd33, 32'h33);
                else        idle();
                step();
                if (o_valid) issues++;
            end
            check("arst_no_issue", 32'(issues), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
